// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: data-memory handshake, load extension, writeback record
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] data_rs2,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state;
  logic [7:0]  wait_cnt;
  logic        acc_load;
  logic [2:0]  acc_funct3;
  logic [1:0]  acc_off;
  logic [4:0]  acc_rd;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        f3_legal;
  logic        aligned;
  logic        mem_go;
  logic        acked;
  logic        expired;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        nm_we;
  logic [31:0] nm_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign mem_go   = accept && f3_legal && aligned;

  // Ack is only honoured while a request is actually outstanding; ack beats timeout.
  assign acked    = dmem_req && dmem_ack;
  assign expired  = !acked && (wait_cnt == CNT_LAST);

  always_comb begin
    f3_legal = 1'b0;
    case (funct3)
      3'd0, 3'd1, 3'd2: f3_legal = is_mem;
      3'd4, 3'd5:       f3_legal = is_load;
      default:          f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = !alu_res[0];
      2'b10:   aligned = (alu_res[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = data_rs2;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << alu_res[1:0];
          req_wdata = {4{data_rs2[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << alu_res[1:0];
          req_wdata = {2{data_rs2[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = data_rs2;
        end
      endcase
    end
  end

  // Record for instructions that never touch memory; memory opcodes fall to the zero default.
  always_comb begin
    nm_we   = 1'b0;
    nm_data = 32'd0;
    case (opcode)
      OP_IMM, OP_REG, OP_LUI, OP_AUIPC: begin
        nm_we   = (rd != 5'd0);
        nm_data = alu_res;
      end
      OP_JAL, OP_JALR: begin
        nm_we   = (rd != 5'd0);
        nm_data = pc + 32'd4;
      end
      default: begin
        nm_we   = 1'b0;
        nm_data = 32'd0;
      end
    endcase
  end

  always_comb begin
    ld_byte  = dmem_rdata[{acc_off, 3'b000} +: 8];
    ld_half  = acc_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = dmem_rdata;
    case (acc_funct3)
      3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_val = {24'd0, ld_byte};
      3'd5:    load_val = {16'd0, ld_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      acc_load    <= 1'b0;
      acc_funct3  <= 3'd0;
      acc_off     <= 2'd0;
      acc_rd      <= 5'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_be     <= 4'd0;
      dmem_wdata  <= 32'd0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wb_rd <= rd;
            if (mem_go) begin
              state      <= S_WAIT;
              wait_cnt   <= 8'd0;
              acc_load   <= is_load;
              acc_funct3 <= funct3;
              acc_off    <= alu_res[1:0];
              acc_rd     <= rd;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_res[31:2], 2'b00};
              dmem_be    <= req_be;
              dmem_wdata <= req_wdata;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= nm_we;
              wb_data  <= nm_data;
              misalign <= is_mem && f3_legal && !aligned;
            end
          end
        end
        S_WAIT: begin
          if (acked) begin
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= acc_rd;
            wb_we    <= acc_load && (acc_rd != 5'd0);
            wb_data  <= acc_load ? load_val : 32'd0;
          end else if (expired) begin
            state       <= S_IDLE;
            dmem_req    <= 1'b0;
            wb_valid    <= 1'b1;
            wb_rd       <= acc_rd;
            wb_we       <= 1'b0;
            wb_data     <= 32'd0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a behavioural RV32I memory-stage model
module tb_mem_stage;

  localparam int TO = 4;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] IMM   = 7'b0010011;
  localparam logic [6:0] REG   = 7'b0110011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] FENCE = 7'b0001111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_res;
  logic [31:0] data_rs2;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .opcode(opcode), .funct3(funct3), .alu_res(alu_res),
    .data_rs2(data_rs2), .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        to;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_mem_op(input logic [6:0] op);
    return (op == LOAD) || (op == STORE);
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == LOAD) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f3 <= 3'd2;
  endfunction

  function automatic bit aligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] w;
    logic [31:0] v;
    w = rdata >> (8 * (addr % 4));
    v = rdata;
    if (acc_size(f3) == 1) begin
      v = w & 32'hFF;
      if (f3 < 4 && v >= 32'h80) v = v - 32'h100;
    end else if (acc_size(f3) == 2) begin
      v = w & 32'hFFFF;
      if (f3 < 4 && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [4:0] rd_i, input logic [31:0] pc_i, input int d,
                                 input logic [31:0] rdata);
    rec_t r;
    r.we = 1'b0; r.rd = rd_i; r.data = 32'd0; r.mis = 1'b0; r.to = 1'b0;
    if (is_mem_op(op)) begin
      if (!legal(op, f3)) return r;
      if (!aligned(f3, addr)) r.mis = 1'b1;
      else if (d > TO) r.to = 1'b1;
      else if (op == LOAD) begin
        r.we   = (rd_i != 0);
        r.data = load_value(f3, addr, rdata);
      end
    end else if (op == IMM || op == REG || op == LUI || op == AUIPC) begin
      r.we = (rd_i != 0); r.data = addr;
    end else if (op == JAL || op == JALR) begin
      r.we = (rd_i != 0); r.data = pc_i + 32'd4;
    end
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    rec_t e;
    if (rst === 1'b0) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("wb_we", 32'(wb_we), 32'(e.we));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          check("misalign", 32'(misalign), 32'(e.mis));
          check("timeout_err", 32'(timeout_err), 32'(e.to));
        end
      end else if (misalign || timeout_err) begin
        check("stray_pulse", {30'd0, misalign, timeout_err}, 32'd0);
      end
    end
  end

  // d = number of cycles dmem_req is high before ack; d > TO means no ack at all.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] pc_i, input logic [4:0] rd_i,
                       input int d, input logic [31:0] rdata);
    int   hi;
    int   sz;
    bit   go;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    opcode = op; funct3 = f3; alu_res = addr; data_rs2 = rs2; pc = pc_i; rd = rd_i;
    in_valid = 1'b1;
    dmem_ack = 1'($urandom_range(0, 1));
    go = is_mem_op(op) && legal(op, f3) && aligned(f3, addr);
    exp_q.push_back(model(op, f3, addr, rd_i, pc_i, d, rdata));
    @(posedge clk);
    #1 in_valid = 1'b0;
    dmem_ack = 1'b0;
    if (go) begin
      sz     = acc_size(f3);
      exp_be = (op == LOAD || sz == 4) ? 32'hF : ((32'd1 << sz) - 1) << (addr % 4);
      exp_wd = (sz == 1) ? rs2[7:0] * 32'h01010101 : (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      hi = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (!dmem_req) break;
        if (hi == 0) begin
          check("dmem_addr", dmem_addr, addr - (addr % 4));
          check("dmem_we", 32'(dmem_we), 32'(op == STORE));
          check("dmem_be", 32'(dmem_be), exp_be);
          if (op == STORE) check("dmem_wdata", dmem_wdata, exp_wd);
        end
        check("in_ready_wait", 32'(in_ready), 32'd0);
        hi++;
        if (hi == d) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      dmem_ack = 1'b0;
      check("req_cycles", 32'(hi), 32'((d <= TO) ? d : TO));
      check("in_ready_after", 32'(in_ready), 32'd1);
    end else if (is_mem_op(op)) begin
      @(negedge clk);
      check("no_req", 32'(dmem_req), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("records_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [6:0] ops [11] = '{LOAD, STORE, IMM, REG, LUI, AUIPC, JAL, JALR, BR, SYS, FENCE};

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc = 0; opcode = 0; funct3 = 0; alu_res = 0;
    data_rs2 = 0; rd = 0; dmem_ack = 1'b0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req", {28'd0, dmem_req, dmem_we, wb_valid, wb_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb", {wb_data[26:0], wb_rd}, 32'd0);
    check("rst_pulses", {30'd0, misalign, timeout_err}, 32'd0);
    rst = 1'b0;

    issue(IMM, 3'd0, 32'h0000_1234, 32'd0, 32'h100, 5'd5, 0, 0);
    issue(IMM, 3'd0, 32'h0000_1234, 32'd0, 32'h104, 5'd0, 0, 0);
    issue(JAL, 3'd0, 32'h0, 32'd0, 32'hFFFF_FFFC, 5'd1, 0, 0);
    issue(LOAD, 3'd0, 32'h103, 32'd0, 32'h0, 5'd7, 3, 32'h80FF_0000);
    issue(LOAD, 3'd4, 32'h103, 32'd0, 32'h0, 5'd7, 3, 32'h80FF_0000);
    issue(STORE, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 5'd3, 2, 32'h0);
    issue(LOAD, 3'd2, 32'h301, 32'd0, 32'h0, 5'd4, 1, 32'h0);
    issue(LOAD, 3'd2, 32'h300, 32'd0, 32'h0, 5'd4, TO + 1, 32'h0);
    issue(LOAD, 3'd2, 32'h308, 32'd0, 32'h0, 5'd9, TO, 32'h1234_5678);
    issue(LOAD, 3'd3, 32'h300, 32'd0, 32'h0, 5'd4, 1, 32'h0);
    issue(STORE, 3'd0, 32'h203, 32'h0000_00A5, 32'h0, 5'd0, 1, 32'h0);

    for (int n = 0; n < 300; n++) begin
      issue(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, 5'($urandom_range(0, 31)), $urandom_range(1, TO + 2), $urandom);
    end
    drain();

    @(negedge clk);
    opcode = LOAD; funct3 = 3'd2; alu_res = 32'h400; rd = 5'd6; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst_test_req_up", 32'(dmem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(dmem_req), 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd1);
    check("rst_async_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_wb_after_rst", 32'(wb_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
